mem_arbiter: RTL and testbench

//  Shares the single-port 16-bit data memory between the CPU control unit and a DMA/debug port.

---
 rtl/mem_arbiter_if.sv | 24 ++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   One requester's request/acknowledge channel into mem_arbiter. There is one
//   instance for the CPU control unit and one for the DMA/debug port.
//   Signals:
//     req        requester -> arbiter  access request, held until ack
//     we         requester -> arbiter  1 = write, 0 = read
//     byte_half  requester -> arbiter  byte/half select, forwarded to memory
//     addr       requester -> arbiter  16-bit byte address
//     wdata      requester -> arbiter  16-bit write data
//     ack        arbiter -> requester  one-cycle completion pulse
//     rdata      arbiter -> requester  read data, valid while ack = 1, else 0
//   Modports: master = requester side, slave = arbiter side.
interface mem_arbiter_if;
  logic        req;
  logic        we;
  logic        byte_half;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;

  modport master (output req, we, byte_half, addr, wdata, input ack, rdata);
  modport slave  (input req, we, byte_half, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single-port 16-bit data memory between the CPU control unit and
//   a DMA/debug port. One access is in flight at a time and takes three cycles:
//   IDLE (grant) -> ISSUE (address/write presented) -> RESP (ack + read data).
//   The CPU has fixed priority; a starvation counter forces a DMA grant after
//   STARVE_MAX consecutive CPU grants made while the DMA was waiting.
//   Ports:
//     clk            rising-edge clock
//     rst            synchronous reset, active-high
//     cpu            CPU requester channel (mem_arbiter_if.slave)
//     dma            DMA/debug requester channel (mem_arbiter_if.slave)
//     mem_out        memory read data, valid the cycle after the address
//     mem_addr       memory address
//     mem_in         memory write data
//     mem_we         memory write enable
//     mem_byte_half  memory byte/half select
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave cpu,
  mem_arbiter_if.slave dma,
  input  logic [15:0]  mem_out,
  output logic [15:0]  mem_addr,
  output logic [15:0]  mem_in,
  output logic         mem_we,
  output logic         mem_byte_half
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_next;
  owner_t     owner, owner_next;
  logic [3:0] starve_cnt, starve_next;

  // Request fields of whichever side currently owns the memory.
  logic        sel_we;
  logic        sel_byte;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;

  assign sel_we    = (owner == OWN_DMA) ? dma.we        : cpu.we;
  assign sel_byte  = (owner == OWN_DMA) ? dma.byte_half : cpu.byte_half;
  assign sel_addr  = (owner == OWN_DMA) ? dma.addr      : cpu.addr;
  assign sel_wdata = (owner == OWN_DMA) ? dma.wdata     : cpu.wdata;

  // NOTE: reset is sampled on the clock edge only, so it sits inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      starve_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from
      // pre-edge values, independent of statement order.
      state      <= state_next;
      owner      <= owner_next;
      starve_cnt <= starve_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next  = state;
    owner_next  = owner;
    starve_next = starve_cnt;
    unique case (state)
      IDLE: begin
        if (cpu.req || dma.req) begin
          state_next = ISSUE;
          // DMA wins when the CPU is silent, or when it has waited through
          // STARVE_MAX CPU grants.
          owner_next = (dma.req && (!cpu.req || starve_cnt == STARVE_LIM))
                       ? OWN_DMA : OWN_CPU;
          if (owner_next == OWN_DMA || !dma.req) begin
            starve_next = '0;
          end else if (starve_cnt != STARVE_LIM) begin
            starve_next = starve_cnt + 4'd1;
          end
        end
      end
      ISSUE:   state_next = RESP;
      // Always back to IDLE so an acked req is never resampled here.
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_addr      = '0;
    mem_in        = '0;
    mem_we        = 1'b0;
    mem_byte_half = 1'b0;
    cpu.ack       = 1'b0;
    cpu.rdata     = '0;
    dma.ack       = 1'b0;
    dma.rdata     = '0;
    unique case (state)
      ISSUE: begin
        mem_addr      = sel_addr;
        mem_in        = sel_wdata;
        mem_we        = sel_we;
        mem_byte_half = sel_byte;
      end
      RESP: begin
        mem_addr      = sel_addr;
        mem_byte_half = sel_byte;
        // A reset arriving during RESP aborts the access: the ack is withheld.
        if (!rst) begin
          if (owner == OWN_DMA) begin
            dma.ack   = 1'b1;
            dma.rdata = mem_out;
          end else begin
            cpu.ack   = 1'b1;
            cpu.rdata = mem_out;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A behavioural memory sits behind the
//   arbiter. A cycle-timeline model (grant cycle, consecutive-CPU-grant count,
//   shadow memory) predicts every output on every falling edge; directed
//   sequences add hand-computed literal expectations on top.
module tb_mem_arbiter;
  localparam int STARVE_MAX = 4;
  localparam byte CH_C = 8'h43;  // 'C'
  localparam byte CH_D = 8'h44;  // 'D'

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_out = '0;
  logic [15:0] mem_addr;
  logic [15:0] mem_in;
  logic        mem_we;
  logic        mem_byte_half;

  mem_arbiter_if cpu_if ();
  mem_arbiter_if dma_if ();

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu          (cpu_if),
    .dma          (dma_if),
    .mem_out      (mem_out),
    .mem_addr     (mem_addr),
    .mem_in       (mem_in),
    .mem_we       (mem_we),
    .mem_byte_half(mem_byte_half)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- memory behind the arbiter ----------------
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic [15:0] ram [0:65535];

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_in;
    mem_out <= ram[mem_addr];
  end

  // ---------------- behavioural model ----------------
  // m_grant is the cycle in which the current access was granted; the access
  // presents its address at m_grant+1 and acks at m_grant+2.
  int          m_grant = -100;
  int          m_streak = 0;
  bit          m_dma = 1'b0;
  bit          model_ready = 1'b0;
  logic [15:0] shadow [0:65535];

  function automatic logic own_we();
    return m_dma ? dma_if.we : cpu_if.we;
  endfunction
  function automatic logic own_byte();
    return m_dma ? dma_if.byte_half : cpu_if.byte_half;
  endfunction
  function automatic logic [15:0] own_addr();
    return m_dma ? dma_if.addr : cpu_if.addr;
  endfunction
  function automatic logic [15:0] own_wdata();
    return m_dma ? dma_if.wdata : cpu_if.wdata;
  endfunction

  always @(posedge clk) begin
    if (pl_en) shadow[pl_addr] = pl_data;
    if (cyc == m_grant + 1 && own_we()) shadow[own_addr()] = own_wdata();
    if (rst) begin
      m_grant     = -100;
      m_streak    = 0;
      m_dma       = 1'b0;
      model_ready = 1'b1;
    end else if (cyc >= m_grant + 3 && (cpu_if.req || dma_if.req)) begin
      m_dma = dma_if.req && (!cpu_if.req || m_streak == STARVE_MAX);
      if (m_dma || !dma_if.req) m_streak = 0;
      else if (m_streak < STARVE_MAX) m_streak++;
      m_grant = cyc;
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  int cmp_ph;
  bit e_cack, e_dack;

  always @(negedge clk) begin
    if (model_ready) begin
      cmp_ph = cyc - m_grant;
      e_cack = (cmp_ph == 2) && !m_dma && !rst;
      e_dack = (cmp_ph == 2) &&  m_dma && !rst;
      check("cpu_ack", cpu_if.ack, e_cack);
      check("dma_ack", dma_if.ack, e_dack);
      if (!e_cack)           check("cpu_rdata", cpu_if.rdata, 16'h0);
      else if (!cpu_if.we)   check("cpu_rdata", cpu_if.rdata, shadow[cpu_if.addr]);
      if (!e_dack)           check("dma_rdata", dma_if.rdata, 16'h0);
      else if (!dma_if.we)   check("dma_rdata", dma_if.rdata, shadow[dma_if.addr]);
      check("mem_we", mem_we, (cmp_ph == 1) ? own_we() : 1'b0);
      check("mem_addr", mem_addr, (cmp_ph == 1 || cmp_ph == 2) ? own_addr() : 16'h0);
      if (cmp_ph == 1) begin
        check("mem_in", mem_in, own_wdata());
        check("mem_byte_half", mem_byte_half, own_byte());
      end else if (cmp_ph != 2) begin
        check("mem_in", mem_in, 16'h0);
        check("mem_byte_half", mem_byte_half, 1'b0);
      end
    end
  end

  // ---------------- observed ack log and write-enable count ----------------
  byte ack_who [$];
  int  ack_cyc [$];
  int  we_cnt = 0;

  always @(negedge clk) begin
    if (cpu_if.ack) begin ack_who.push_back(CH_C); ack_cyc.push_back(cyc); end
    if (dma_if.ack) begin ack_who.push_back(CH_D); ack_cyc.push_back(cyc); end
    if (mem_we) we_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit is_dma, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input bit bh, input bit keep,
                        output logic [15:0] rdata, output int ack_at);
    int waited;
    bit got;
    waited = 0;
    got    = 1'b0;
    rdata  = '0;
    ack_at = -1;
    if (is_dma) begin
      dma_if.we = we; dma_if.addr = addr; dma_if.wdata = wdata; dma_if.byte_half = bh;
      dma_if.req = 1'b1;
    end else begin
      cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata; cpu_if.byte_half = bh;
      cpu_if.req = 1'b1;
    end
    while (!got && waited < 40) begin
      @(negedge clk);
      waited++;
      if (is_dma ? dma_if.ack : cpu_if.ack) begin
        got    = 1'b1;
        rdata  = is_dma ? dma_if.rdata : cpu_if.rdata;
        ack_at = cyc;
      end
    end
    check(is_dma ? "dma_ack_seen" : "cpu_ack_seen", got, 1'b1);
    tick();
    if (!keep) begin
      if (is_dma) dma_if.req = 1'b0;
      else        cpu_if.req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [15:0] rd_c, rd_d;
  int          at_c, at_d, base, idx0, d_first, d_second;
  string       exp_order;
  logic [15:0] pre_addr [6];
  logic [15:0] pre_data [6];

  initial begin
    cpu_if.req = 0; cpu_if.we = 0; cpu_if.byte_half = 0; cpu_if.addr = '0; cpu_if.wdata = '0;
    dma_if.req = 0; dma_if.we = 0; dma_if.byte_half = 0; dma_if.addr = '0; dma_if.wdata = '0;
    pre_addr = '{16'h0010, 16'h0030, 16'h0040, 16'h0041, 16'h0042, 16'h0043};
    pre_data = '{16'hBEEF, 16'hCAFE, 16'h1111, 16'h2222, 16'h3333, 16'h4444};

    // Reset, with the memory preloaded while the arbiter is held in reset.
    rst = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      pl_en = 1'b1; pl_addr = pre_addr[i]; pl_data = pre_data[i];
      tick();
    end
    pl_en = 1'b0;
    @(negedge clk);
    check("rst_mem", {mem_we, mem_byte_half, mem_addr, mem_in}, 0);
    check("rst_ack", {cpu_if.ack, dma_if.ack, cpu_if.rdata, dma_if.rdata}, 0);
    check("rst_starve", dut.starve_cnt, 4'd0);
    tick();

    // Simultaneous first request after reset: CPU first, DMA next.
    rst  = 1'b0;
    base = cyc;
    idx0 = ack_who.size();
    fork
      access(1'b0, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, rd_c, at_c);
      access(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, rd_d, at_d);
    join
    check("sim_cpu_ack_cycle", at_c - base, 2);
    check("sim_dma_ack_cycle", at_d - base, 5);
    check("sim_cpu_rdata", rd_c, 16'hBEEF);
    check("sim_dma_rdata", rd_d, 16'hCAFE);
    check("sim_ack_count", ack_who.size() - idx0, 2);

    // CPU read, stepped cycle by cycle.
    cpu_if.we = 0; cpu_if.addr = 16'h0010; cpu_if.byte_half = 0; cpu_if.req = 1'b1;
    @(negedge clk);
    check("rd_n0_addr", mem_addr, 16'h0);
    tick();
    @(negedge clk);
    check("rd_n1_addr", mem_addr, 16'h0010);
    check("rd_n1_we", mem_we, 1'b0);
    tick();
    @(negedge clk);
    check("rd_n2_ack", {cpu_if.ack, dma_if.ack}, 2'b10);
    check("rd_n2_rdata", cpu_if.rdata, 16'hBEEF);
    tick();
    cpu_if.req = 1'b0;
    tick();

    // DMA write (byte select set), then CPU read-back.
    idx0 = we_cnt;
    access(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0, rd_d, at_d);
    check("dma_wr_we_cycles", we_cnt - idx0, 1);
    access(1'b0, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, rd_c, at_c);
    check("cpu_readback", rd_c, 16'h1234);

    // Starvation: both sides keep requesting; DMA forced after 4 CPU grants.
    idx0 = ack_who.size();
    base = cyc;
    fork
      for (int i = 0; i < 8; i++) begin
        logic [15:0] r;
        int a;
        access(1'b0, 1'b0, 16'h0040 + 16'(i % 4), 16'h0, 1'b0, i < 7, r, a);
      end
      begin
        logic [15:0] r0;
        int a0;
        access(1'b1, 1'b1, 16'h0050, 16'hD00D, 1'b0, 1'b1, r0, a0);
        access(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b0, rd_d, at_d);
      end
    join
    exp_order = "CCCCDCCCCD";
    check("starve_count", ack_who.size() - idx0, 10);
    if (ack_who.size() - idx0 == 10) begin
      for (int i = 0; i < 10; i++) check("starve_order", ack_who[idx0 + i], exp_order[i]);
      d_first  = ack_cyc[idx0 + 4];
      d_second = ack_cyc[idx0 + 9];
      check("starve_d1_cycle", d_first - base, 14);
      check("starve_d_spacing", d_second - d_first, 15);
    end
    check("starve_dma_readback", rd_d, 16'hD00D);

    // Reset in the RESP cycle of a CPU read, with DMA also waiting.
    idx0 = ack_who.size();
    cpu_if.we = 0; cpu_if.addr = 16'h0030; cpu_if.req = 1'b1;
    dma_if.we = 0; dma_if.addr = 16'h0040; dma_if.req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    cpu_if.req = 1'b0;
    dma_if.req = 1'b0;
    @(negedge clk);
    check("rstmid_no_ack", {cpu_if.ack, dma_if.ack}, 2'b00);
    check("rstmid_starve_before", dut.starve_cnt, 4'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_mem", {mem_we, mem_byte_half, mem_addr, mem_in}, 0);
    check("rstmid_rdata", {cpu_if.rdata, dma_if.rdata}, 0);
    check("rstmid_starve_after", dut.starve_cnt, 4'd0);
    check("rstmid_ack_count", ack_who.size() - idx0, 0);
    tick();
    base = cyc;
    access(1'b0, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, rd_c, at_c);
    check("rstmid_after_cycle", at_c - base, 2);
    check("rstmid_after_rdata", rd_c, 16'hBEEF);

    // Idle: nothing requested for 20 cycles.
    idx0 = ack_who.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_mem", {mem_we, mem_addr}, 0);
      check("idle_ack", {cpu_if.ack, dma_if.ack, cpu_if.rdata, dma_if.rdata}, 0);
      tick();
    end
    check("idle_ack_count", ack_who.size() - idx0, 0);
    base = cyc;
    access(1'b1, 1'b0, 16'h0041, 16'h0, 1'b0, 1'b0, rd_d, at_d);
    check("idle_then_dma_cycle", at_d - base, 2);
    check("idle_then_dma_rdata", rd_d, 16'h2222);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
